reg_writeback: RTL
==================

# reg_writeback

Writeback stage that drives the integer register file's single write port (`rd`, `wr_en`, `wr_data`) for the RV64IM core. It merges two result producers:

- the in-order pipeline, for ALU and load results;
- the multi-cycle mul/div unit, for M-extension results.

It formats load data, suppresses writes to x0, and keeps a pending-destination scoreboard for in-flight mul/div operations. The write outputs are registered, so the register file's same-cycle read bypass sees a stable write.

## Interface
- `MD_MAX_WAIT`, default 4: maximum cycles a buffered mul/div result may wait behind pipeline results (range 1–15).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pipe_valid` in 1: pipeline result valid.
- `pipe_ready` out 1: pipeline result accepted when `pipe_valid && pipe_ready`.
- `pipe_rd` in 5: destination register.
- `pipe_data` in 64: ALU result, or raw aligned 64-bit load doubleword.
- `pipe_fmt` in 3: result format, FMT_D=0 (pass), FMT_B, FMT_H, FMT_W, FMT_BU, FMT_HU, FMT_WU.
- `pipe_addr_lo` in 3: load address bits [2:0].
- `md_issue` in 1: mul/div operation issued this cycle.
- `md_issue_rd` in 5: destination of the issued operation.
- `md_valid` in 1: mul/div result valid.
- `md_ready` out 1: mul/div result accepted when `md_valid && md_ready`.
- `md_rd` in 5: mul/div destination register.
- `md_data` in 64: mul/div result, already W-extended by the producer.
- `wr_en` out 1: register file write enable, registered.
- `rd` out 5: register file write address, registered.
- `wr_data` out 64: register file write data, registered.
- `pend_mask` out 32: bit n=1 means a mul/div write to xn is outstanding.
- `sb_err` out 1: sticky flag; set when an issue targets an already-pending register.

## Operation
**One-entry mul/div holding buffer**
- State: `buf_full`, `buf_rd`, `buf_data`, age counter `age` (4 bits).
- `md_ready = !buf_full`, registered.
- An accepted mul/div result loads the buffer.

**Arbitration, evaluated each cycle**
- `drain = buf_full && (!pipe_valid || age == MD_MAX_WAIT)`.
- `pipe_ready = !(buf_full && age == MD_MAX_WAIT)`.
- A pipeline handshake writes the pipeline result. Otherwise, `drain` writes the buffer and clears `buf_full` and `age`.
- While `buf_full` and no drain, `age` increments, saturating at `MD_MAX_WAIT`.

**Write outputs**
- The selected result registers into `rd`/`wr_data`.
- `wr_en` is 1 only when a result was selected and its rd ≠ 0.
- rd=0 results are still handshaken, then dropped.

**Scoreboard (`pend_mask`)**
- `md_issue` with `md_issue_rd` ≠ 0 sets that bit next cycle.
- A buffer drain clears bit `buf_rd`. The clear takes effect in the same edge as the `wr_en` registration.
- Issue and clear of the same rd in one cycle: the bit ends set.
- Issue to a bit already set: the bit stays set and `sb_err` is set.
- Bit 0 is constant 0.

**Load formatting**
- Byte: `pipe_data[8*addr_lo +: 8]`.
- Half: `[16*addr_lo[2:1] +: 16]`.
- Word: `[32*addr_lo[2] +: 32]`.
- Sign-extend for B/H/W, zero-extend for BU/HU/WU.
- Address bits below the access granularity are ignored.

## Timing
- Reset values: `wr_en`=0, `rd`=0, `wr_data`=0, `pend_mask`=0, `sb_err`=0, `md_ready`=1, `buf_full`=0, `age`=0.
- Pipeline result handshaken at T → `wr_en` at T+1.
- Mul/div result accepted at T → earliest drain at T+1 → `wr_en` at T+2. `md_ready` is 0 during T+1.
- Mul/div worst-case wait: drained no later than T+1+MD_MAX_WAIT.
- `pipe_ready` is low for exactly one cycle per forced drain.
- Back-to-back mul/div results: `md_ready` returns high the cycle after the drain. Maximum throughput is one result per 2 cycles.
- Reset mid-operation: the buffered result is discarded, `pend_mask` clears, and no write is issued on reset release.

## Configuration
- `WB_LOAD_FMT_EN` defined: load extraction and sign/zero extension are active as above.
- `WB_LOAD_FMT_EN` undefined: `pipe_fmt` and `pipe_addr_lo` are ignored, and `pipe_data` passes through unchanged (loads are formatted upstream).

## Structure
- Shared package `rv64_pkg`:
  - `wb_fmt_t` enum (FMT_D…FMT_WU);
  - `XLEN` = 64;
  - `REG_AW` = 5.
- One sub-module: `load_formatter`, combinational extraction/extension. It is instantiated only under `WB_LOAD_FMT_EN`.

## Test plan
- **Reset and basic pipeline write:** deassert reset; `pipe_valid`=1, rd=5, data=0x1234, fmt=FMT_D → next cycle `wr_en`=1, rd=5, `wr_data`=0x1234.
- **x0 suppression:** pipeline write with rd=0, data=0xFFFF → `pipe_ready`=1, and `wr_en` stays 0.
- **Load formatting:** data=0x80FF_0000_0000_0000, addr_lo=7.
  - FMT_B → `wr_data`=0xFFFF_FFFF_FFFF_FF80.
  - FMT_BU → 0x80.
  - FMT_HU at addr_lo=6 → 0x80FF.
- **Starvation limit:** mul/div result rd=9 buffered while `pipe_valid` is held continuously → drain at the 5th cycle after acceptance (MD_MAX_WAIT=4), `pipe_ready`=0 that cycle, then the rd=9 write.
- **Scoreboard:**
  - `md_issue` rd=12 → `pend_mask[12]`=1.
  - Second issue rd=12 → `sb_err`=1.
  - Drain of rd=12 → bit clears in the same cycle `wr_en`=1.
- **Reset mid-operation:** buffer full with rd=3 and `pend_mask[3]`=1; assert `rst` asynchronously → `pend_mask`=0, `md_ready`=1, and no write to x3 after release.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared RV64 definitions used by the writeback stage: datapath widths and
// the load result format encoding carried with every pipeline result.
package rv64_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   // Pipeline result format; FMT_D passes the 64-bit value through untouched.
   typedef enum logic [2:0] {
      FMT_D  = 3'd0,
      FMT_B  = 3'd1,
      FMT_H  = 3'd2,
      FMT_W  = 3'd3,
      FMT_BU = 3'd4,
      FMT_HU = 3'd5,
      FMT_WU = 3'd6
   } wb_fmt_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of the writeback stage's producer handshakes, scoreboard issue port
// and register-file write port.
//
// Handshake rule for both result channels (pipe_* and md_*): the producer
// raises valid with stable payload and holds it until the cycle where
// valid && ready is seen at the rising edge; that cycle is the transfer.
// Ready never depends on valid in a way that forms a combinational loop.
//
// master: the producers / register file side.  slave: the writeback stage.
interface reg_writeback_if;
   import rv64_pkg::*;

   logic                  pipe_valid;
   logic                  pipe_ready;
   logic [REG_AW-1:0]     pipe_rd;
   logic [XLEN-1:0]       pipe_data;
   wb_fmt_t               pipe_fmt;
   logic [2:0]            pipe_addr_lo;

   logic                  md_issue;
   logic [REG_AW-1:0]     md_issue_rd;
   logic                  md_valid;
   logic                  md_ready;
   logic [REG_AW-1:0]     md_rd;
   logic [XLEN-1:0]       md_data;

   logic                  wr_en;
   logic [REG_AW-1:0]     rd;
   logic [XLEN-1:0]       wr_data;
   logic [31:0]           pend_mask;
   logic                  sb_err;

   modport master (
      output pipe_valid, pipe_rd, pipe_data, pipe_fmt, pipe_addr_lo,
      output md_issue, md_issue_rd, md_valid, md_rd, md_data,
      input  pipe_ready, md_ready,
      input  wr_en, rd, wr_data, pend_mask, sb_err
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, pipe_fmt, pipe_addr_lo,
      input  md_issue, md_issue_rd, md_valid, md_rd, md_data,
      output pipe_ready, md_ready,
      output wr_en, rd, wr_data, pend_mask, sb_err
   );

endinterface

// File: rtl/reg_writeback_load_formatter.sv
// load_formatter: combinational extraction of a byte/half/word from an
// aligned load doubleword plus sign or zero extension. Address bits below
// the access size are ignored, so misaligned offsets round down.
module load_formatter
   import rv64_pkg::*;
(
   input  logic [XLEN-1:0] i_data,
   input  wb_fmt_t         i_fmt,
   input  logic [2:0]      i_addr_lo,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_word;

   // Select the addressed lane, then extend according to the format.
   always_comb begin
      w_byte = i_data[{i_addr_lo, 3'b000} +: 8];
      w_half = i_data[{i_addr_lo[2:1], 4'b0000} +: 16];
      w_word = i_data[{i_addr_lo[2], 5'b00000} +: 32];
      o_data = i_data;
      case (i_fmt)
         FMT_B:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         FMT_H:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
         FMT_W:   o_data = {{(XLEN-32){w_word[31]}}, w_word};
         FMT_BU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
         FMT_HU:  o_data = {{(XLEN-16){1'b0}}, w_half};
         FMT_WU:  o_data = {{(XLEN-32){1'b0}}, w_word};
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: drives the integer register file write port, merging
// in-order pipeline results with buffered mul/div results. A mul/div result
// waits in a one-entry buffer while the pipeline has results, but never more
// than MD_MAX_WAIT cycles; then the pipeline is stalled for one cycle.
// Also keeps a pending-destination mask for in-flight mul/div operations.
// Optional feature macro: WB_LOAD_FMT_EN enables load extraction/extension;
// without it pipeline data is written unchanged.
module reg_writeback
   import rv64_pkg::*;
#(
   parameter int unsigned MD_MAX_WAIT = 4
)(
   input  logic clk,
   input  logic rst,
   reg_writeback_if.slave wb
);

   localparam logic [3:0] AGE_MAX = 4'(MD_MAX_WAIT);

   // Holding buffer state
   logic              r_buf_full;
   logic [REG_AW-1:0] r_buf_rd;
   logic [XLEN-1:0]   r_buf_data;
   logic [3:0]        r_age;
   logic              r_md_ready;

   // Registered write port and scoreboard
   logic              r_wr_en;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_wr_data;
   logic [31:0]       r_pend_mask;
   logic              r_sb_err;

   logic              w_age_max;
   logic              w_pipe_ready;
   logic              w_pipe_fire;
   logic              w_md_fire;
   logic              w_drain;
   logic              w_buf_full_next;
   logic              w_sel_valid;
   logic [REG_AW-1:0] w_sel_rd;
   logic [XLEN-1:0]   w_sel_data;
   logic [XLEN-1:0]   w_pipe_wdata;
   logic [31:0]       w_pend_next;
   logic              w_issue_dup;

`ifdef WB_LOAD_FMT_EN
   load_formatter u_load_formatter (
      .i_data    (wb.pipe_data),
      .i_fmt     (wb.pipe_fmt),
      .i_addr_lo (wb.pipe_addr_lo),
      .o_data    (w_pipe_wdata)
   );
`else
   // Loads arrive already formatted; format and address are not needed.
   logic w_unused_fmt;
   assign w_unused_fmt = ^{wb.pipe_fmt, wb.pipe_addr_lo};
   assign w_pipe_wdata = wb.pipe_data;
`endif

   // Arbitration: pipeline first, buffer when idle or when it has aged out.
   always_comb begin
      w_age_max       = r_buf_full && (r_age == AGE_MAX);
      w_pipe_ready    = !w_age_max;
      w_pipe_fire     = wb.pipe_valid && w_pipe_ready;
      w_md_fire       = wb.md_valid && r_md_ready;
      w_drain         = r_buf_full && (!wb.pipe_valid || w_age_max);
      w_sel_valid     = w_pipe_fire || w_drain;
      w_sel_rd        = r_buf_rd;
      w_sel_data      = r_buf_data;
      if (w_pipe_fire) begin
         w_sel_rd   = wb.pipe_rd;
         w_sel_data = w_pipe_wdata;
      end
      // A buffer can only accept while empty, so load and drain never overlap.
      w_buf_full_next = r_buf_full;
      if (w_md_fire) begin
         w_buf_full_next = 1'b1;
      end else if (w_drain) begin
         w_buf_full_next = 1'b0;
      end
   end

   // Scoreboard update: drain clears, a same-cycle issue wins, x0 never set.
   always_comb begin
      w_pend_next = r_pend_mask;
      w_issue_dup = wb.md_issue && (wb.md_issue_rd != '0) && r_pend_mask[wb.md_issue_rd];
      if (w_drain) begin
         w_pend_next[r_buf_rd] = 1'b0;
      end
      if (wb.md_issue && (wb.md_issue_rd != '0)) begin
         w_pend_next[wb.md_issue_rd] = 1'b1;
      end
      w_pend_next[0] = 1'b0;
   end

   // Holding buffer: load on accept, empty on drain, age while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_full <= 1'b0;
         r_buf_rd   <= '0;
         r_buf_data <= '0;
         r_age      <= '0;
         r_md_ready <= 1'b1;
      end else begin
         r_buf_full <= w_buf_full_next;
         r_md_ready <= !w_buf_full_next;
         if (w_md_fire) begin
            r_buf_rd   <= wb.md_rd;
            r_buf_data <= wb.md_data;
            r_age      <= '0;
         end else if (w_drain) begin
            r_age      <= '0;
         end else if (r_buf_full && (r_age != AGE_MAX)) begin
            r_age      <= r_age + 4'd1;
         end
      end
   end

   // Registered write port; x0 results are consumed but never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_rd      <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_sel_valid && (w_sel_rd != '0);
         if (w_sel_valid) begin
            r_rd      <= w_sel_rd;
            r_wr_data <= w_sel_data;
         end
      end
   end

   // Pending mask and sticky double-issue flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_mask <= '0;
         r_sb_err    <= 1'b0;
      end else begin
         r_pend_mask <= w_pend_next;
         if (w_issue_dup) begin
            r_sb_err <= 1'b1;
         end
      end
   end

   assign wb.pipe_ready = w_pipe_ready;
   assign wb.md_ready   = r_md_ready;
   assign wb.wr_en      = r_wr_en;
   assign wb.rd         = r_rd;
   assign wb.wr_data    = r_wr_data;
   assign wb.pend_mask  = r_pend_mask;
   assign wb.sb_err     = r_sb_err;

endmodule
